// File: rtl/uart_receiver_pkg.sv
// Shared defines for the UART receiver: FSM encodings, status bit layout, accumulator mux codes.
// Define UART_PARITY_EN to add the even-parity bit and its PARITY state.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_PARITY_EN
    , PARITY = 3'd4
`endif
  } rxState_t;

  localparam int uartStatLen   = 8;
  localparam int statRxReady   = 0;
  localparam int statOverrun   = 1;
  localparam int statFrameErr  = 2;
  localparam int statParityErr = 3;
  localparam int statBusy      = 4;

  // Accumulator input mux selects; the receiver feeds the two UART legs.
  typedef enum logic [1:0] {
    accSelAlu      = 2'd0,
    accSelMem      = 2'd1,
    accSelUartData = 2'd2,
    accSelUartStat = 2'd3
  } accMuxSel_t;

  function automatic logic [uartStatLen-1:0] packStat(
    input logic rxReady, input logic overrun, input logic frameErr,
    input logic parityErr, input logic busy);
    logic [uartStatLen-1:0] s;
    s = '0;
    s[statRxReady]   = rxReady;
    s[statOverrun]   = overrun;
    s[statFrameErr]  = frameErr;
    s[statParityErr] = parityErr;
    s[statBusy]      = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Core-side register port of the UART receiver: read strobes in, data/status bytes out.
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  logic                   dataRd;
  logic                   statRd;
  logic [7:0]             uartDataOut;
  logic [uartStatLen-1:0] uartStatOut;

  modport master (output dataRd, statRd, input uartDataOut, uartStatOut);
  modport slave  (input dataRd, statRd, output uartDataOut, uartStatOut);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both flops reset to rstVal.
module sync_2ff #(
  parameter logic rstVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= rstVal;
      q    <= rstVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with rxReady/overrun/frame (and optional parity) status.
// Define UART_PARITY_EN for 8E1 framing with parity checking.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int BIT_PERIOD = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic rxIn,
  uart_receiver_if.slave bus
);
  // The state register adds a cycle after the synchronizer, so the start-bit
  // sample fires on the edge the count reaches BIT_PERIOD/2, landing mid-bit.
  localparam logic [15:0] halfMark = 16'(BIT_PERIOD / 2 - 1);
  localparam logic [15:0] lastMark = 16'(BIT_PERIOD - 1);

  logic       rxSync;
  rxState_t   state, stateNext;
  logic [15:0] cnt;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg;
  logic [7:0] dataReg;
  logic       rxReady, overrun, frameErr, parityErr;
  logic       cntClr, shiftEn, frameDone;

  sync_2ff #(.rstVal(1'b1)) uSync (
    .clk   (clk),
    .reset (reset),
    .d     (rxIn),
    .q     (rxSync)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

`ifdef UART_PARITY_EN
  logic parityEn;
  logic parityBad;
`endif

  always_comb begin
    stateNext = state;
    cntClr    = 1'b0;
    shiftEn   = 1'b0;
    frameDone = 1'b0;
`ifdef UART_PARITY_EN
    parityEn  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cntClr = 1'b1;
        if (!rxSync) stateNext = START;
      end
      START: begin
        if (cnt == halfMark) begin
          cntClr    = 1'b1;
          stateNext = rxSync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == lastMark) begin
          cntClr  = 1'b1;
          shiftEn = 1'b1;
          if (bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (cnt == lastMark) begin
          cntClr    = 1'b1;
          parityEn  = 1'b1;
          stateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == lastMark) begin
          cntClr    = 1'b1;
          frameDone = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        cntClr    = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      cnt <= cntClr ? 16'd0 : cnt + 16'd1;
      if (state == IDLE) bitIdx <= '0;
      else if (shiftEn)  bitIdx <= bitIdx + 3'd1;
      if (shiftEn) shiftReg <= {rxSync, shiftReg[7:1]};
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)         parityBad <= 1'b0;
    else if (parityEn) parityBad <= rxSync ^ (^shiftReg);
  end

  always_ff @(posedge clk) begin
    if (reset) parityErr <= 1'b0;
    else if (frameDone && parityBad) parityErr <= 1'b1;
    else if (bus.statRd)             parityErr <= 1'b0;
  end
`else
  assign parityErr = 1'b0;
`endif

  // Clears are written first so a flag set on the same edge overrides them.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataReg  <= '0;
      rxReady  <= 1'b0;
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (bus.statRd) begin
        overrun  <= 1'b0;
        frameErr <= 1'b0;
      end
      if (bus.dataRd) rxReady <= 1'b0;
      if (frameDone) begin
        if (!rxSync) frameErr <= 1'b1;
        if (!rxReady || bus.dataRd) begin
          dataReg <= shiftReg;
          rxReady <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.uartDataOut = dataReg;
  assign bus.uartStatOut = packStat(rxReady, overrun, frameErr, parityErr, state != IDLE);
endmodule
